// File: rtl/inv_shift_rows_stream.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_stream
//   Byte-serial InvShiftRows stage for the AES decoder datapath. A 16-byte
//   state arrives one byte per transfer in column-major order
//   (index = row + 4*col) and leaves in the same order with each row r
//   rotated right by r positions. Two ping-pong banks let one block load
//   while the other drains, sustaining 1 byte/cycle in each direction.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   inv_en     1 = InvShiftRows, 0 = pass-through; sampled on a block's first byte
//   in_valid   in_data holds a valid byte
//   in_ready   write bank is free to accept a byte
//   in_data    input state byte
//   out_valid  read bank holds a complete block
//   out_ready  downstream accepts out_data
//   out_data   output state byte (0 when out_valid=0)
//   out_last   marks output byte index 15 of a block
//   busy       any bank full, or a partial block is loading
// ---------------------------------------------------------------------------
module inv_shift_rows_stream #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    logic [BYTE_W-1:0] r_bank0 [16];
    logic [BYTE_W-1:0] r_bank1 [16];
    logic [1:0]        r_full;
    logic [1:0]        r_inv;
    logic              r_wr_bank;
    logic [3:0]        r_wr_cnt;
    logic              r_rd_bank;
    logic [3:0]        r_rd_cnt;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_done;
    logic              w_rd_done;
    logic [1:0]        w_full_nxt;
    logic [1:0]        w_row;
    logic [1:0]        w_col;
    logic [1:0]        w_src_col;
    logic [3:0]        w_src;
    logic [BYTE_W-1:0] w_rd_byte;

    assign in_ready  = ~r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_last  = out_valid && (r_rd_cnt == 4'd15);
    assign busy      = (|r_full) | (r_wr_cnt != 4'd0);

    assign w_wr_acc  = in_valid && in_ready;
    assign w_rd_acc  = out_valid && out_ready;
    assign w_wr_done = w_wr_acc && (r_wr_cnt == 4'd15);
    assign w_rd_done = w_rd_acc && (r_rd_cnt == 4'd15);

    // Output byte (r,c) comes from (r, (c - r) mod 4); 2-bit subtraction
    // wraps naturally.
    assign w_row     = r_rd_cnt[1:0];
    assign w_col     = r_rd_cnt[3:2];
    assign w_src_col = w_col - w_row;

    always_comb begin
        w_src = r_rd_cnt;
        if (r_inv[r_rd_bank]) begin
            w_src = {w_src_col, w_row};
        end
    end

    always_comb begin
        w_rd_byte = r_rd_bank ? r_bank1[w_src] : r_bank0[w_src];
        out_data  = out_valid ? w_rd_byte : '0;
    end

    // A set needs the bank empty and a clear needs it full, so the two never
    // hit the same bit in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
            r_full    <= '0;
            r_inv     <= '0;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
        end else begin
            r_full <= w_full_nxt;

            if (w_wr_acc) begin
                if (r_wr_bank) begin
                    r_bank1[r_wr_cnt] <= in_data;
                end else begin
                    r_bank0[r_wr_cnt] <= in_data;
                end
                if (r_wr_cnt == 4'd0) begin
                    r_inv[r_wr_bank] <= inv_en;
                end
                r_wr_cnt <= r_wr_cnt + 4'd1;
                if (r_wr_cnt == 4'd15) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (w_rd_acc) begin
                r_rd_cnt <= r_rd_cnt + 4'd1;
                if (r_rd_cnt == 4'd15) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// ---------------------------------------------------------------------------
// tb_inv_shift_rows_stream
//   Self-checking bench for inv_shift_rows_stream: directed table of
//   single-block vectors, backpressure and reset sequences, and randomized
//   streaming checked against a block-level reference model.
// ---------------------------------------------------------------------------
module tb_inv_shift_rows_stream;

    logic       clk;
    logic       rst;
    logic       inv_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    inv_shift_rows_stream #(.BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .inv_en    (inv_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // out_ready driver: 0 = hold low, 1 = hold high, 2 = random
    int ready_mode = 1;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: gathers each accepted block, then queues its 16 output
    // bytes computed directly from the row-rotation rule.
    logic [7:0] mblk [16];
    int         mcnt = 0;
    logic       minv = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         out_pos = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcnt       = 0;
            out_pos    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (!out_valid) begin
                check("idle_data_zero", out_data, 8'h00);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1'b1, 1'b0);
                end else begin
                    check("sb_data", out_data, exp_q.pop_front());
                end
                check("sb_last", out_last, (out_pos == 15));
                got_q.push_back(out_data);
                out_pos = (out_pos + 1) % 16;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            if (in_valid && in_ready) begin
                if (mcnt == 0) minv = inv_en;
                mblk[mcnt] = in_data;
                mcnt++;
                if (mcnt == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        int r, c, s;
                        r = k % 4;
                        c = k / 4;
                        s = minv ? (r + 4 * ((c - r + 4) % 4)) : k;
                        exp_q.push_back(mblk[s]);
                    end
                    mcnt = 0;
                end
            end
        end
    end

    // Present one byte and hold it until accepted. in_valid stays high on
    // return so back-to-back calls stream at full rate.
    task automatic push_byte(input logic [7:0] d, input logic ie, input int stall_pct);
        int   guard;
        logic acc;
        if (stall_pct > 0) begin
            while ($urandom_range(0, 99) < stall_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        inv_en   = ie;
        guard    = 0;
        acc      = 1'b0;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) timeout("push_byte");
    endtask

    task automatic wait_drain(input int budget);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < budget) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= budget) timeout("drain");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 8'h00);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    typedef struct packed {
        logic         inv;
        int           tog;      // byte index where inv_en flips to 1, -1 = never
        logic [127:0] din;      // byte i at [8*i +: 8]
        logic [127:0] dexp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        rst      = 1'b1;
        inv_en   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        vecs[0] = '{inv: 1'b1, tog: -1,
                    din:  128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    dexp: 128'h03060900_0F020508_0B0E0104_070A0D00 | 128'h00000C00_00000000_00000000_00000000};
        vecs[0].dexp = 128'h0306090C_0F020508_0B0E0104_070A0D00;
        vecs[1] = '{inv: 1'b1, tog: -1,
                    din:  128'h0B06010C_07020D08_030E0904_0F0A0500,
                    dexp: 128'h0F0E0D0C_0B0A0908_07060504_03020100};
        vecs[2] = '{inv: 1'b0, tog: -1,
                    din:  128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    dexp: 128'h0F0E0D0C_0B0A0908_07060504_03020100};
        vecs[3] = '{inv: 1'b0, tog: 5,
                    din:  128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    dexp: 128'h0F0E0D0C_0B0A0908_07060504_03020100};

        #2;
        check_reset_outputs("por");
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed single-block vectors
        for (int v = 0; v < 4; v++) begin
            got_q.delete();
            for (int i = 0; i < 16; i++) begin
                logic ie;
                ie = (vecs[v].tog >= 0 && i >= vecs[v].tog) ? 1'b1 : vecs[v].inv;
                push_byte(vecs[v].din[8*i +: 8], ie, 0);
                if (i == 14) check("lat_before_last", out_valid, 1'b0);
            end
            in_valid = 1'b0;
            check("lat_first_valid", out_valid, 1'b1);
            check("lat_first_data", out_data, vecs[v].dexp[7:0]);
            wait_drain(200);
            check("vec_count", got_q.size(), 16);
            for (int i = 0; i < 16 && i < got_q.size(); i++) begin
                check($sformatf("vec%0d_b%0d", v, i), got_q[i], vecs[v].dexp[8*i +: 8]);
            end
        end

        // Backpressure: two blocks fill both banks, third must wait
        ready_mode = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        got_q.delete();
        for (int i = 0; i < 32; i++) begin
            push_byte(8'(i * 7 + 3), (i >= 16), 0);
        end
        in_valid = 1'b0;
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_busy", busy, 1'b1);
        begin
            int   guard;
            logic found;
            guard = 0;
            found = 1'b0;
            ready_mode = 1;
            while (!found && guard < 100) begin
                @(negedge clk);
                if (out_valid && out_ready && out_last) begin
                    check("bp_ready_at_last", in_ready, 1'b0);
                    @(negedge clk);
                    check("bp_ready_rise", in_ready, 1'b1);
                    found = 1'b1;
                end
                guard++;
            end
            if (!found) timeout("bp_last");
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(200 - i), 1'b1, 0);
        end
        in_valid = 1'b0;
        wait_drain(300);
        check("bp_total", got_q.size(), 48);

        // Randomized streaming with stalls on both sides
        ready_mode = 2;
        for (int b = 0; b < 20; b++) begin
            logic ie;
            ie = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                push_byte(8'($urandom), ie, 30);
            end
        end
        in_valid = 1'b0;
        ready_mode = 1;
        wait_drain(2000);

        // Reset mid-load (wr_cnt = 7)
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            push_byte(8'(i + 16), 1'b1, 0);
        end
        in_valid = 1'b0;
        check("midload_busy", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_load");
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i * 16 + 1), 1'b1, 0);
        end
        in_valid = 1'b0;
        wait_drain(200);
        check("after_rst_load_count", got_q.size(), 16);

        // Reset mid-drain (rd_cnt = 9)
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i + 100), 1'b1, 0);
        end
        in_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (got_q.size() < 9 && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 100) timeout("mid_drain");
        end
        check("middrain_count", got_q.size(), 9);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_drain");
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(255 - i * 3), 1'b1, 0);
        end
        in_valid = 1'b0;
        wait_drain(200);
        check("after_rst_drain_count", got_q.size(), 16);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_shift_rows_stream.md
Name: inv_shift_rows_stream

Overview:
- Byte-serial (SISO) InvShiftRows stage for the AES decoder datapath; the inverse counterpart of the encoder ShiftRows step.
- Accepts a 16-byte state one byte per transfer, in column-major order (byte index i = row + 4*col).
- Emits the 16 inverse-row-shifted bytes serially in the same column-major order.
- Two ping-pong banks let one block load while the previous block drains, so streaming runs at 1 byte/cycle.

Parameters:
- BYTE_W, 8, width of one state byte; only 8 is supported for AES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- inv_en  input  1  1 = apply InvShiftRows, 0 = pass bytes through unchanged. Sampled per block.
- in_valid  input  1  in_data holds a valid byte.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  BYTE_W  input state byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BYTE_W  output state byte.
- out_last  output  1  marks output byte index 15 of a block.
- busy  output  1  any bank full, or a partial block is loading.

Behaviour:
- State registers:
  - bank0/bank1: 16 x BYTE_W each.
  - full[1:0], inv[1:0].
  - wr_bank, wr_cnt[3:0], rd_bank, rd_cnt[3:0].
- Reset (async, rst=1): every register above clears to 0. Outputs at reset are in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Reset while a block is loading or draining discards all data; there is no partial output after reset.
- Input handshake:
  - in_ready = !full[wr_bank].
  - A byte is accepted when in_valid && in_ready. It is written to bank[wr_bank][wr_cnt], and wr_cnt increments.
  - On the accept with wr_cnt==0, inv[wr_bank] <= inv_en. inv_en is ignored for the rest of that block.
  - On the accept with wr_cnt==15: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
  - While in_ready=0, in_data and in_valid are don't-care.
- Output handshake:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][src(rd_cnt)] when out_valid=1, else 0.
  - out_last = out_valid && rd_cnt==15.
  - A transfer occurs on out_valid && out_ready, and rd_cnt increments. On the transfer with rd_cnt==15: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
  - out_data, out_valid and out_last hold stable while out_valid && !out_ready.
- Index map src(k):
  - inv=0: src(k) = k.
  - inv=1: src(r+4c) = r + 4*((c-r) mod 4).
  - Explicitly, k -> src(k):
    - 0->0, 1->13, 2->10, 3->7
    - 4->4, 5->1, 6->14, 7->11
    - 8->8, 9->5, 10->2, 11->15
    - 12->12, 13->9, 14->6, 15->3
- Latency:
  - First output byte has out_valid=1 in the cycle after the 16th input byte is accepted.
  - With out_ready held high and the input streaming, sustained throughput is 1 byte/cycle in and 1 byte/cycle out.
- Boundary conditions:
  - Both banks full: in_ready=0 until the drain of rd_bank completes. in_ready rises in the cycle after the final (index 15) output transfer.
  - Set and clear in the same cycle always target different banks, since a set needs !full and a clear needs full. Both updates apply.
  - A byte is never overwritten while its bank is full.
  - busy = full[0] | full[1] | (wr_cnt != 0).

Test Plan:
- Single block, inv_en=1, in_data=0x00..0x0F, out_ready=1 -> out_data = 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03. out_last only on the 16th byte. First out_valid appears 1 cycle after the 16th accept.
- Round trip, inv_en=1, input = encoder ShiftRows of 0x00..0x0F, i.e. 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B -> output = 00,01,...,0F.
- Bypass, inv_en=0, input 0x00..0x0F -> output 0x00..0x0F. Then toggle inv_en to 1 at input byte 5 of the same block -> that block's output is still identity.
- Backpressure, out_ready=0, stream 3 blocks -> blocks 1-2 fill both banks and in_ready drops at the 33rd byte. Then raise out_ready -> in_ready rises in the cycle after output byte 15 of block 1. All 48 bytes are correct and in order.
- Random out_ready and in_valid stalls over 20 blocks with mixed inv_en -> every byte matches the reference model, and out_data is held stable during every stall.
- Assert rst for 1 cycle mid-load (wr_cnt=7) and mid-drain (rd_cnt=9) -> all outputs go to their reset values immediately. A new block after reset produces exactly 16 correct bytes.
